// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and pointer-width helper.
// Pointers carry one extra wrap bit above the address bits.
package fifo_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 32;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array, no reset.
// Synchronous write port, address-decoded read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered in the top so data_out can be reset
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip select and registered read data.
// Pointers, accept gating and full/empty flags live here.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_w(FIFO_DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign we = cs & wr_en & ~full;
  assign re = cs & rd_en & ~empty;

  fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (re) begin
        rd_ptr   <= rd_ptr + PW'(1);
        data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed checks of sync_fifo against a queue model.
// Model tracks contents as a plain queue of accepted writes.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         empty;
  logic         full;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] mq [$];
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, update the model from pre-edge occupancy, check
  task automatic step(input logic r, input logic c,
                      input logic w, input logic rd,
                      input logic [W-1:0] d);
    bit was_full;
    bit was_empty;
    rst = r; cs = c; wr_en = w; rd_en = rd; data_in = d;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      if (c && rd && !was_empty) m_dout = mq.pop_front();
      if (c && w && !was_full) mq.push_back(d);
    end
    chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    chk("dout", data_out, m_dout);
  endtask

  task automatic wr(input logic [W-1:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    m_dout = '0;

    // 1: reset state and underflow read
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_dout", data_out, 32'd0);
    rd();
    chk("underflow_dout", data_out, 32'd0);

    // 2: three writes, three reads
    wr(32'd1); wr(32'd10); wr(32'd100);
    rd(); chk("t2_r0", data_out, 32'd1);
    rd(); chk("t2_r1", data_out, 32'd10);
    rd(); chk("t2_r2", data_out, 32'd100);
    chk("t2_empty", {31'b0, empty}, 32'd1);

    // 3: alternating pairs across the wrap
    for (int i = 0; i < 8; i++) begin
      wr(32'd1 << i);
      rd();
      chk("t3_rd", data_out, 32'd1 << i);
    end

    // 4: fill, overflow, drain
    for (int i = 0; i < 9; i++) begin
      wr(32'd1 << i);
      if (i == 7) chk("t4_full", {31'b0, full}, 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("t4_rd", data_out, 32'd1 << i);
    end
    chk("t4_empty", {31'b0, empty}, 32'd1);

    // 5: simultaneous access when full, then half full
    for (int i = 0; i < 8; i++) wr(32'h100 + i);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hdead);
    chk("t5_oldest", data_out, 32'h100);
    chk("t5_notfull", {31'b0, full}, 32'd0);
    for (int i = 0; i < 3; i++) rd();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200 + i);
    chk("t5_occ", 32'(mq.size()), 32'd4);

    // 6: reset mid-operation, then cs gating
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'hbeef);
    wr(32'h11); wr(32'h22); wr(32'h33);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h44);
    chk("t6_rst_empty", {31'b0, empty}, 32'd1);
    wr(32'h55);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h66);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h77);
    rd();
    chk("t6_cs_rd", data_out, 32'h55);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
